// File: rtl/icu_seq_if.sv
// icu_seq_if: program-memory / I/O bus bundle for the icu_seq control unit.
//   pc          : address of the current instruction (driven by the sequencer)
//   instruction : 4-bit opcode read at pc
//   operand     : AW-bit operand read at pc (I/O address or jump target)
//   data_in     : W-bit I/O read data for io_addr
//   io_addr     : I/O address, equal to the current operand
//   data_out    : registered store data
//   wr_addr     : registered store address
//   write       : registered one-cycle store strobe
// master = sequencer side, slave = memory / I/O side.
interface icu_seq_if #(
    parameter int W  = 8,
    parameter int AW = 8
);
    logic [AW-1:0] pc;
    logic [3:0]    instruction;
    logic [AW-1:0] operand;
    logic [W-1:0]  data_in;
    logic [AW-1:0] io_addr;
    logic [W-1:0]  data_out;
    logic [AW-1:0] wr_addr;
    logic          write;

    modport master (
        output pc, io_addr, data_out, wr_addr, write,
        input  instruction, operand, data_in
    );

    modport slave (
        input  pc, io_addr, data_out, wr_addr, write,
        output instruction, operand, data_in
    );
endinterface

// File: rtl/icu_seq.sv
// icu_seq: W-bit industrial control unit with an internal program counter
// and a D-deep return-address stack. One instruction per clock while
// i_hold is low.
//   i_clk      : clock, posedge
//   i_rst      : synchronous active-high reset (overrides i_hold)
//   i_hold     : freeze architectural state, suppress pulses
//   bus        : program memory / I/O bus (icu_seq_if.master)
//   o_rr_out   : result register
//   o_flag_o   : pulse, NOPO executed
//   o_flag_f   : pulse, NOPF executed
//   o_stk_ovf  : sticky, JMP with full stack
//   o_stk_unf  : sticky, RTN with empty stack
module icu_seq #(
    parameter int W  = 8,
    parameter int AW = 8,
    parameter int D  = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_hold,
    icu_seq_if.master    bus,
    output logic [W-1:0] o_rr_out,
    output logic         o_flag_o,
    output logic         o_flag_f,
    output logic         o_stk_ovf,
    output logic         o_stk_unf
);
    localparam logic [3:0] OP_NOPO = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_LDC  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_ANDC = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_ORC  = 4'h6;
    localparam logic [3:0] OP_XNOR = 4'h7;
    localparam logic [3:0] OP_STO  = 4'h8;
    localparam logic [3:0] OP_STOC = 4'h9;
    localparam logic [3:0] OP_IEN  = 4'hA;
    localparam logic [3:0] OP_OEN  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RTN  = 4'hD;
    localparam logic [3:0] OP_SKZ  = 4'hE;
    localparam logic [3:0] OP_NOPF = 4'hF;

    // sp counts 0..D inclusive; the stack index only needs to reach D-1
    localparam int SPW = $clog2(D + 1);
    localparam int IW  = (D > 1) ? $clog2(D) : 1;

    logic [AW-1:0]  r_pc;
    logic [W-1:0]   r_rr;
    logic           r_ien;
    logic           r_oen;
    logic           r_skip;
    logic [SPW-1:0] r_sp;
    logic [AW-1:0]  r_stack [D];
    logic [W-1:0]   r_data_out;
    logic [AW-1:0]  r_wr_addr;
    logic           r_write;
    logic           r_flag_o;
    logic           r_flag_f;
    logic           r_ovf;
    logic           r_unf;

    logic [W-1:0]   w_dm;
    logic [AW-1:0]  w_pc_inc;
    logic [SPW-1:0] w_sp_dec;
    logic [IW-1:0]  w_push_idx;
    logic [IW-1:0]  w_pop_idx;
    logic           w_full;
    logic           w_empty;
    logic           w_exec;

    assign w_dm       = bus.data_in & {W{r_ien}};
    assign w_pc_inc   = r_pc + AW'(1);
    assign w_sp_dec   = r_sp - SPW'(1);
    assign w_push_idx = r_sp[IW-1:0];
    assign w_pop_idx  = w_sp_dec[IW-1:0];
    assign w_full     = (r_sp == SPW'(D));
    assign w_empty    = (r_sp == '0);
    assign w_exec     = !i_hold && !r_skip;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc       <= '0;
            r_rr       <= '0;
            r_ien      <= 1'b0;
            r_oen      <= 1'b0;
            r_skip     <= 1'b0;
            r_sp       <= '0;
            r_data_out <= '0;
            r_wr_addr  <= '0;
            r_write    <= 1'b0;
            r_flag_o   <= 1'b0;
            r_flag_f   <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            // pulses default low, including hold cycles
            r_write  <= 1'b0;
            r_flag_o <= 1'b0;
            r_flag_f <= 1'b0;
            if (!i_hold) begin
                r_pc <= w_pc_inc;
                if (r_skip) begin
                    r_skip <= 1'b0;
                end else begin
                    case (bus.instruction)
                        OP_NOPO: r_flag_o <= 1'b1;
                        OP_LD:   r_rr <= w_dm;
                        OP_LDC:  r_rr <= ~w_dm;
                        OP_AND:  r_rr <= r_rr & w_dm;
                        OP_ANDC: r_rr <= r_rr & ~w_dm;
                        OP_OR:   r_rr <= r_rr | w_dm;
                        OP_ORC:  r_rr <= r_rr | ~w_dm;
                        OP_XNOR: r_rr <= ~(r_rr ^ w_dm);
                        OP_STO, OP_STOC: begin
                            if (r_oen) begin
                                r_write    <= 1'b1;
                                r_data_out <= (bus.instruction == OP_STOC) ? ~r_rr : r_rr;
                                r_wr_addr  <= bus.operand;
                            end
                        end
                        OP_IEN:  r_ien <= bus.data_in[0];
                        OP_OEN:  r_oen <= w_dm[0];
                        OP_JMP: begin
                            if (!w_full) r_sp  <= r_sp + SPW'(1);
                            else         r_ovf <= 1'b1;
                            r_pc <= bus.operand;
                        end
                        OP_RTN: begin
                            if (!w_empty) begin
                                r_sp <= w_sp_dec;
                                r_pc <= r_stack[w_pop_idx];
                            end else begin
                                r_pc  <= '0;
                                r_unf <= 1'b1;
                            end
                            // the instruction after a return is always discarded
                            r_skip <= 1'b1;
                        end
                        OP_SKZ:  if (r_rr == '0) r_skip <= 1'b1;
                        OP_NOPF: r_flag_f <= 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Stack contents survive reset; only sp is cleared.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_exec && bus.instruction == OP_JMP && !w_full)
            r_stack[w_push_idx] <= w_pc_inc;
    end

    assign bus.pc       = r_pc;
    assign bus.io_addr  = bus.operand;
    assign bus.data_out = r_data_out;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.write    = r_write;
    assign o_rr_out     = r_rr;
    assign o_flag_o     = r_flag_o;
    assign o_flag_f     = r_flag_f;
    assign o_stk_ovf    = r_ovf;
    assign o_stk_unf    = r_unf;
endmodule

// File: tb/tb_icu_seq.sv
module tb_icu_seq;
    localparam logic [3:0] NOPO = 4'h0, LD = 4'h1, LDC = 4'h2, AND = 4'h3,
                           ANDC = 4'h4, OR = 4'h5, ORC = 4'h6, XNOR = 4'h7,
                           STO = 4'h8, STOC = 4'h9, IEN = 4'hA, OEN = 4'hB,
                           JMP = 4'hC, RTN = 4'hD, SKZ = 4'hE, NOPF = 4'hF;

    typedef struct {
        int         tgt;
        logic [7:0] pc;
        logic [7:0] rr;
        logic       wr;
        logic       fo;
        logic       ff;
        logic       ov;
        logic       un;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        logic [7:0] a;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic hold;
    logic [7:0] rr_out;
    logic flag_o, flag_f, stk_ovf, stk_unf;

    icu_seq_if #(.W(8), .AW(8)) bus ();

    icu_seq #(.W(8), .AW(8), .D(4)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_hold    (hold),
        .bus       (bus),
        .o_rr_out  (rr_out),
        .o_flag_o  (flag_o),
        .o_flag_f  (flag_f),
        .o_stk_ovf (stk_ovf),
        .o_stk_unf (stk_unf)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t eq[$];
    wr_t  wq[$];
    logic e_ovf = 1'b0;
    logic e_unf = 1'b0;
    exp_t m_e;
    wr_t  m_w;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: per-cycle state expectations plus write-transaction scoreboard.
    always @(negedge clk) begin
        while (eq.size() > 0 && eq[0].tgt == cyc) begin
            m_e = eq.pop_front();
            chk("pc",      32'(bus.pc),  32'(m_e.pc));
            chk("rr",      32'(rr_out),  32'(m_e.rr));
            chk("write",   32'(bus.write), 32'(m_e.wr));
            chk("flag_o",  32'(flag_o),  32'(m_e.fo));
            chk("flag_f",  32'(flag_f),  32'(m_e.ff));
            chk("stk_ovf", 32'(stk_ovf), 32'(m_e.ov));
            chk("stk_unf", 32'(stk_unf), 32'(m_e.un));
        end
        if (bus.write === 1'b1) begin
            if (wq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write (cycle %0d): data %0h addr %0h, expected none",
                         cyc, bus.data_out, bus.wr_addr);
            end else begin
                m_w = wq.pop_front();
                chk("wr_data", 32'(bus.data_out), 32'(m_w.d));
                chk("wr_addr", 32'(bus.wr_addr),  32'(m_w.a));
            end
        end
    end

    // Drive one instruction and queue what should be visible after its posedge.
    task automatic step(input logic [3:0] op, input logic [7:0] opnd, input logic [7:0] din,
                        input logic hd, input logic rs,
                        input logic [7:0] epc, input logic [7:0] err,
                        input logic ewr, input logic [7:0] ewd, input logic [1:0] efl);
        exp_t e;
        wr_t  w;
        bus.instruction = op;
        bus.operand     = opnd;
        bus.data_in     = din;
        hold            = hd;
        rst             = rs;
        e.tgt = cyc + 1;
        e.pc  = epc;
        e.rr  = err;
        e.wr  = ewr;
        e.fo  = efl[1];
        e.ff  = efl[0];
        e.ov  = e_ovf;
        e.un  = e_unf;
        eq.push_back(e);
        if (ewr) begin
            w.d = ewd;
            w.a = opnd;
            wq.push_back(w);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        rst = 1'b1;
        hold = 1'b0;
        bus.instruction = NOPO;
        bus.operand = 8'h00;
        bus.data_in = 8'h00;
        //    op    opnd   din    hd rs  pc     rr     wr wd     fl
        step(NOPO, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 0, 8'h00, 2'b00); // reset
        // load / store
        step(IEN,  8'h00, 8'h01, 0, 0, 8'h01, 8'h00, 0, 8'h00, 2'b00);
        step(OEN,  8'h00, 8'h01, 0, 0, 8'h02, 8'h00, 0, 8'h00, 2'b00);
        step(LD,   8'h00, 8'hA5, 0, 0, 8'h03, 8'hA5, 0, 8'h00, 2'b00);
        step(STO,  8'h10, 8'h00, 0, 0, 8'h04, 8'hA5, 1, 8'hA5, 2'b00);
        step(NOPO, 8'h00, 8'h00, 0, 0, 8'h05, 8'hA5, 0, 8'h00, 2'b10);
        // masked input and complement ops
        step(IEN,  8'h00, 8'h00, 0, 0, 8'h06, 8'hA5, 0, 8'h00, 2'b00);
        step(LDC,  8'h00, 8'h3C, 0, 0, 8'h07, 8'hFF, 0, 8'h00, 2'b00);
        step(ORC,  8'h00, 8'hFF, 0, 0, 8'h08, 8'hFF, 0, 8'h00, 2'b00);
        step(IEN,  8'h00, 8'h01, 0, 0, 8'h09, 8'hFF, 0, 8'h00, 2'b00);
        step(ANDC, 8'h00, 8'h0F, 0, 0, 8'h0A, 8'hF0, 0, 8'h00, 2'b00);
        step(XNOR, 8'h00, 8'hF0, 0, 0, 8'h0B, 8'hFF, 0, 8'h00, 2'b00);
        // SKZ taken, then not taken
        step(LD,   8'h00, 8'h00, 0, 0, 8'h0C, 8'h00, 0, 8'h00, 2'b00);
        step(SKZ,  8'h00, 8'h00, 0, 0, 8'h0D, 8'h00, 0, 8'h00, 2'b00);
        step(STO,  8'h20, 8'h00, 0, 0, 8'h0E, 8'h00, 0, 8'h00, 2'b00);
        step(LD,   8'h00, 8'h01, 0, 0, 8'h0F, 8'h01, 0, 8'h00, 2'b00);
        step(SKZ,  8'h00, 8'h00, 0, 0, 8'h10, 8'h01, 0, 8'h00, 2'b00);
        step(STO,  8'h21, 8'h00, 0, 0, 8'h11, 8'h01, 1, 8'h01, 2'b00);
        // OR / AND / STOC / NOPF / OEN gating
        step(OR,   8'h00, 8'hF0, 0, 0, 8'h12, 8'hF1, 0, 8'h00, 2'b00);
        step(AND,  8'h00, 8'h3C, 0, 0, 8'h13, 8'h30, 0, 8'h00, 2'b00);
        step(STOC, 8'h22, 8'h00, 0, 0, 8'h14, 8'h30, 1, 8'hCF, 2'b00);
        step(NOPF, 8'h00, 8'h00, 0, 0, 8'h15, 8'h30, 0, 8'h00, 2'b01);
        step(OEN,  8'h00, 8'h00, 0, 0, 8'h16, 8'h30, 0, 8'h00, 2'b00);
        step(STO,  8'h23, 8'h00, 0, 0, 8'h17, 8'h30, 0, 8'h00, 2'b00);
        step(OEN,  8'h00, 8'hFF, 0, 0, 8'h18, 8'h30, 0, 8'h00, 2'b00);
        // nested call/return with post-RTN skip
        step(JMP,  8'h05, 8'h00, 0, 0, 8'h05, 8'h30, 0, 8'h00, 2'b00);
        step(JMP,  8'h40, 8'h00, 0, 0, 8'h40, 8'h30, 0, 8'h00, 2'b00);
        step(RTN,  8'h00, 8'h00, 0, 0, 8'h06, 8'h30, 0, 8'h00, 2'b00);
        step(STO,  8'h30, 8'h00, 0, 0, 8'h07, 8'h30, 0, 8'h00, 2'b00);
        step(RTN,  8'h00, 8'h00, 0, 0, 8'h19, 8'h30, 0, 8'h00, 2'b00);
        step(JMP,  8'h77, 8'h00, 0, 0, 8'h1A, 8'h30, 0, 8'h00, 2'b00);
        // overflow on fifth nested JMP
        step(JMP,  8'h50, 8'h00, 0, 0, 8'h50, 8'h30, 0, 8'h00, 2'b00);
        step(JMP,  8'h60, 8'h00, 0, 0, 8'h60, 8'h30, 0, 8'h00, 2'b00);
        step(JMP,  8'h70, 8'h00, 0, 0, 8'h70, 8'h30, 0, 8'h00, 2'b00);
        step(JMP,  8'h80, 8'h00, 0, 0, 8'h80, 8'h30, 0, 8'h00, 2'b00);
        e_ovf = 1'b1;
        step(JMP,  8'h90, 8'h00, 0, 0, 8'h90, 8'h30, 0, 8'h00, 2'b00);
        // unwind; each skipped slot must have no side effect
        step(RTN,  8'h00, 8'h00, 0, 0, 8'h71, 8'h30, 0, 8'h00, 2'b00);
        step(NOPO, 8'h00, 8'h00, 0, 0, 8'h72, 8'h30, 0, 8'h00, 2'b00);
        step(RTN,  8'h00, 8'h00, 0, 0, 8'h61, 8'h30, 0, 8'h00, 2'b00);
        step(NOPF, 8'h00, 8'h00, 0, 0, 8'h62, 8'h30, 0, 8'h00, 2'b00);
        step(RTN,  8'h00, 8'h00, 0, 0, 8'h51, 8'h30, 0, 8'h00, 2'b00);
        step(LD,   8'h00, 8'h00, 0, 0, 8'h52, 8'h30, 0, 8'h00, 2'b00);
        step(RTN,  8'h00, 8'h00, 0, 0, 8'h1B, 8'h30, 0, 8'h00, 2'b00);
        step(SKZ,  8'h00, 8'h00, 0, 0, 8'h1C, 8'h30, 0, 8'h00, 2'b00);
        e_unf = 1'b1;
        step(RTN,  8'h00, 8'h00, 0, 0, 8'h00, 8'h30, 0, 8'h00, 2'b00);
        step(STO,  8'h44, 8'h00, 0, 0, 8'h01, 8'h30, 0, 8'h00, 2'b00);
        // hold after a store: single write only
        step(LD,   8'h00, 8'h5A, 0, 0, 8'h02, 8'h5A, 0, 8'h00, 2'b00);
        step(STO,  8'h55, 8'h00, 0, 0, 8'h03, 8'h5A, 1, 8'h5A, 2'b00);
        step(STO,  8'h55, 8'h00, 1, 0, 8'h03, 8'h5A, 0, 8'h00, 2'b00);
        step(STO,  8'h55, 8'h00, 1, 0, 8'h03, 8'h5A, 0, 8'h00, 2'b00);
        step(STO,  8'h55, 8'h00, 1, 0, 8'h03, 8'h5A, 0, 8'h00, 2'b00);
        step(NOPO, 8'h00, 8'h00, 0, 0, 8'h04, 8'h5A, 0, 8'h00, 2'b10);
        // reset wins over hold; ien must come back cleared
        e_ovf = 1'b0;
        e_unf = 1'b0;
        step(NOPO, 8'h00, 8'h00, 1, 1, 8'h00, 8'h00, 0, 8'h00, 2'b00);
        step(NOPO, 8'h00, 8'h00, 0, 0, 8'h01, 8'h00, 0, 8'h00, 2'b10);
        step(LDC,  8'h00, 8'hFF, 0, 0, 8'h02, 8'hFF, 0, 8'h00, 2'b00);

        repeat (3) @(posedge clk);
        #1;
        chk("exp_queue_left",   32'(eq.size()), 32'd0);
        chk("write_queue_left", 32'(wq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/icu_seq.md
Name: icu_seq

Overview:
- Parametrised successor of the single-bit industrial control unit: W-bit result register (RR), bitwise logic ops, IEN/OEN gating and SKZ/RTN skip.
- Adds an internal program counter and a D-deep return-address stack, so JMP/RTN are executed in the block instead of being flagged to external sequencing logic.
- Sits between an asynchronous-read program memory (instruction + operand at address pc) and a W-bit I/O bus addressed by the instruction operand.

Parameters:
W, 8, data / result register width in bits (>=1)
AW, 8, program address and operand width in bits
D, 4, return stack depth in entries (>=1)

Ports:
clk  in  1  system clock, all state updates on posedge only
rst  in  1  synchronous active-high reset
hold  in  1  1 = freeze all architectural state; outputs keep their values except write, which is 0
pc  out  AW  address of the current instruction
instruction  in  4  opcode (instruction_t from instructions package) read at pc
operand  in  AW  operand word read at pc: I/O address or jump target
data_in  in  W  I/O read data for the address on io_addr
io_addr  out  AW  combinational: operand of current instruction
data_out  out  W  registered store data
wr_addr  out  AW  registered store address
write  out  1  registered one-cycle store strobe
rr_out  out  W  result register
flag_o  out  1  registered pulse: NOPO executed
flag_f  out  1  registered pulse: NOPF executed
stk_ovf  out  1  sticky: JMP attempted with stack full
stk_unf  out  1  sticky: RTN attempted with stack empty

Behaviour:
- Reset (rst=1 at posedge, overrides hold): pc=0, RR=0, ien=0, oen=0, skip=0, sp=0, data_out=0, wr_addr=0, write=0, flag_o=0, flag_f=0, stk_ovf=0, stk_unf=0.
- One instruction per posedge while hold=0. Dm = data_in & {W{ien}}.
- Opcodes, not skipped; pc <= pc+1 unless stated:
  - NOPO: flag_o=1 next cycle.
  - LD: RR<=Dm.
  - LDC: RR<=~Dm.
  - AND: RR<=RR&Dm.
  - ANDC: RR<=RR&~Dm.
  - OR: RR<=RR|Dm.
  - ORC: RR<=RR|~Dm.
  - XNOR: RR<=~(RR^Dm).
  - STO / STOC: if oen, write<=1, data_out<=RR / ~RR, wr_addr<=operand; otherwise no write.
  - IEN: ien<=data_in[0], unmasked.
  - OEN: oen<=Dm[0].
  - JMP: if sp<D, push pc+1 and sp++; if sp==D, no push and stk_ovf<=1. In both cases pc<=operand.
  - RTN: if sp>0, sp-- and pc<=popped value; if sp==0, pc<=0 and stk_unf<=1. In both cases skip<=1.
  - SKZ: skip<=1 if RR=={W{0}}.
  - NOPF: flag_f=1 next cycle.
- Skip: when skip=1, the instruction at pc executes as a pure NOP:
  - No RR/ien/oen/stack/flag change and no write.
  - pc<=pc+1 and skip<=0.
  - A skipped JMP does not jump; a skipped SKZ/RTN does not set skip.
- write, flag_o and flag_f are single-cycle pulses. They are 0 in any cycle not directly following the qualifying instruction, including hold cycles.
- hold=1: pc, RR, ien, oen, skip, sp, stack, data_out, wr_addr and sticky flags are unchanged. A store pending before hold is not repeated.
- pc wraps modulo 2^AW. Pushed pc+1 wraps identically.
- Stack storage is not cleared by reset; only sp resets. Sticky errors clear only on rst.
- Consecutive JMP/RTN each take one cycle. RTN followed by anything always skips that next instruction.

Test Plan:
- Reset, then IEN (data_in=1), OEN (data_in=8'h01), LD (data_in=8'hA5), STO operand=8'h10 -> one-cycle write=1, data_out=8'hA5, wr_addr=8'h10; rr_out=8'hA5.
- ien=0, LDC, then ORC with data_in=8'hFF -> RR=8'hFF. Then ANDC with ien=1, data_in=8'h0F -> RR=8'hF0. Then XNOR with data_in=8'hF0 -> RR=8'hFF.
- RR=0, SKZ, then STO (oen=1) -> no write, pc advances by 2. Repeat with RR=8'h01 -> write occurs.
- JMP 8'h40 at pc=8'h05 -> pc=8'h40. RTN -> pc=8'h06 and the instruction at 8'h06 is skipped (pc 8'h06 -> 8'h07, no side effect).
- D=4: five nested JMPs -> stk_ovf=1 after the fifth, pc=its operand. Five RTNs -> the fifth gives pc=0, stk_unf=1. Both stay 1 until rst.
- hold=1 for 3 cycles mid-program with STO current -> pc frozen, write=0 throughout, no extra write when hold drops.
- rst asserted with hold=1 -> all reset values next cycle.
